// File: rtl/frame_pkg.sv
// frame_pkg: state encoding, frame byte constants and defaults shared by frame transmitter and receiver.
package frame_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_ID, S_CMD, S_LEN0, S_LEN1, S_P_RD, S_P_TX, S_CSUM, S_FIN
  } frame_state_t;
  localparam logic [7:0] B_PRE = 8'h55;
  localparam logic [7:0] B_SFD = 8'hD5;
  localparam logic [7:0] B_ID  = 8'hFA;
  localparam logic [7:0] B_WR  = 8'hAA;
  localparam logic [7:0] B_RD  = 8'h55;
  localparam logic [7:0] B_NUL = 8'h00;
  localparam int DEF_PAYLOAD_LEN = 40000;
endpackage

// File: rtl/frame_tx.sv
// frame_tx: builds preamble/SFD/ID/CMD/LEN header plus memory payload and streams it to a UART over valid/ready.
// Define FRAME_TX_CHKSUM_EN to append a modulo-256 checksum of CMD through the last payload byte.
module frame_tx
  import frame_pkg::*;
#(
  parameter int PAYLOAD_LEN = DEF_PAYLOAD_LEN,
  parameter int PRE_CNT     = 7
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cmd_sel,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
  localparam logic [15:0] LAST_ADDR = 16'(PAYLOAD_LEN - 1);
  localparam logic [15:0] LAST_PRE  = 16'(PRE_CNT - 1);
`ifdef FRAME_TX_CHKSUM_EN
  localparam frame_state_t TAIL = S_CSUM;
  logic [7:0] r_csum;
`else
  localparam frame_state_t TAIL = S_FIN;
`endif
  frame_state_t r_state, w_next;
  logic        r_cmd, r_rd_pend;
  logic [15:0] r_cnt, r_addr;
  logic [7:0]  r_rd_data;
  logic        w_acc;
  assign w_acc     = tx_valid && tx_ready;
  assign mem_rd_en = r_state == S_P_RD;
  assign mem_addr  = r_addr;
  assign done      = r_state == S_FIN;
  assign busy      = r_state != S_IDLE && r_state != S_FIN;
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_PRE : S_IDLE;
      S_PRE:   w_next = (w_acc && r_cnt == LAST_PRE) ? S_SFD : S_PRE;
      S_SFD:   w_next = w_acc ? S_ID : S_SFD;
      S_ID:    w_next = w_acc ? S_CMD : S_ID;
      S_CMD:   w_next = w_acc ? S_LEN0 : S_CMD;
      S_LEN0:  w_next = w_acc ? S_LEN1 : S_LEN0;
      S_LEN1:  w_next = w_acc ? (r_cmd ? TAIL : S_P_RD) : S_LEN1;
      S_P_RD:  w_next = S_P_TX;
      S_P_TX:  w_next = w_acc ? ((r_addr == LAST_ADDR) ? TAIL : S_P_RD) : S_P_TX;
`ifdef FRAME_TX_CHKSUM_EN
      S_CSUM:  w_next = w_acc ? S_FIN : S_CSUM;
`endif
      default: w_next = S_IDLE;
    endcase
  end
  // Payload byte is only offered once the memory word has landed in r_rd_data.
  always_comb begin
    tx_valid = (r_state inside {S_PRE, S_SFD, S_ID, S_CMD, S_LEN0, S_LEN1, S_CSUM}) ||
               (r_state == S_P_TX && !r_rd_pend);
    case (r_state)
      S_PRE:   tx_data = B_PRE;
      S_SFD:   tx_data = B_SFD;
      S_ID:    tx_data = B_ID;
      S_CMD:   tx_data = r_cmd ? B_RD : B_WR;
      S_P_TX:  tx_data = r_rd_data;
`ifdef FRAME_TX_CHKSUM_EN
      S_CSUM:  tx_data = r_csum;
`endif
      default: tx_data = B_NUL;
    endcase
  end
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      r_cmd     <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_data <= 8'h00;
      r_cnt     <= 16'd0;
      r_addr    <= 16'd0;
`ifdef FRAME_TX_CHKSUM_EN
      r_csum    <= 8'h00;
`endif
    end else begin
      r_rd_pend <= r_state == S_P_RD;
      if (r_rd_pend) r_rd_data <= mem_rd_data;
      if (r_state == S_IDLE && start) begin
        r_cmd  <= cmd_sel;
        r_cnt  <= 16'd0;
        r_addr <= 16'd0;
      end
      if (r_state == S_PRE && w_acc) r_cnt <= (r_cnt == LAST_PRE) ? 16'd0 : r_cnt + 16'd1;
      if (r_state == S_P_TX && w_acc) r_addr <= (r_addr == LAST_ADDR) ? 16'd0 : r_addr + 16'd1;
`ifdef FRAME_TX_CHKSUM_EN
      if (r_state == S_IDLE) r_csum <= 8'h00;
      else if (w_acc && r_state inside {S_CMD, S_LEN0, S_LEN1, S_P_TX}) r_csum <= r_csum + tx_data;
`endif
    end
endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: random-stimulus bench comparing the transmitted byte stream against a frame-level reference queue.
module tb_frame_tx;
  localparam int PL = 8;
  localparam int PC = 7;
  logic       sclk = 0, rst_n = 0, start = 0, cmd_sel = 0, tx_ready = 0;
  logic       mem_rd_en, tx_valid, busy, done;
  logic [15:0] mem_addr;
  logic [7:0] mem_rd_data = 0, tx_data;
  logic [7:0] mem [PL];
  int n_cmp = 0, n_bad = 0, done_cnt = 0, rd_cnt = 0, pct = 100;
  byte unsigned obs_q[$];
  logic stalled = 0;
  logic [7:0] stall_d = 0;
  always #5 sclk = ~sclk;
  frame_tx #(.PAYLOAD_LEN(PL), .PRE_CNT(PC)) dut (
    .sclk(sclk), .rst_n(rst_n), .start(start), .cmd_sel(cmd_sel),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );
  always @(posedge sclk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[2:0]];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge sclk) begin
    if (!rst_n) stalled = 0;
    else begin
      if (stalled) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, stall_d);
      end
      if (tx_valid && tx_ready) obs_q.push_back(tx_data);
      if (done) done_cnt++;
      if (mem_rd_en) begin
        rd_cnt++;
        check("rd_addr_range", mem_addr < PL, 1);
      end
      stalled = tx_valid && !tx_ready;
      stall_d = tx_data;
    end
  end
  initial forever begin
    @(posedge sclk); #1;
    tx_ready = $urandom_range(99) < pct;
  end
  task automatic pulse_start(input bit cmd);
    obs_q.delete();
    done_cnt = 0;
    rd_cnt = 0;
    @(posedge sclk); #1;
    start = 1;
    cmd_sel = cmd;
    @(posedge sclk); #1;
    start = 0;
    cmd_sel = $urandom;
  endtask
  task automatic run_frame(input bit cmd, input bit dbl, input string tag);
    byte unsigned exp_q[$];
    int sum = 0, t = 0;
    bit pulsed = 0;
    for (int i = 0; i < PC; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'hFA);
    exp_q.push_back(cmd ? 8'h55 : 8'hAA);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    if (!cmd) for (int i = 0; i < PL; i++) exp_q.push_back(mem[i]);
`ifdef FRAME_TX_CHKSUM_EN
    for (int i = PC + 2; i < exp_q.size(); i++) sum += exp_q[i];
    exp_q.push_back(8'(sum));
`endif
    pulse_start(cmd);
    check($sformatf("%s_busy_rise", tag), busy, 1);
    while (done_cnt == 0 && t < 5000) begin
      @(posedge sclk); #1;
      t++;
      start = 0;
      if (dbl && !pulsed && rd_cnt == 3) begin
        start = 1;
        cmd_sel = ~cmd;
        pulsed = 1;
      end
    end
    start = 0;
    check($sformatf("%s_timeout", tag), t < 5000, 1);
    repeat (30) @(posedge sclk);
    #1;
    check($sformatf("%s_len", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
    check($sformatf("%s_done_cnt", tag), done_cnt, 1);
    check($sformatf("%s_rd_cnt", tag), rd_cnt, cmd ? 0 : PL);
    check($sformatf("%s_busy_end", tag), busy, 0);
    check($sformatf("%s_addr_end", tag), mem_addr, 0);
  endtask
  task automatic check_idle_outputs(input string tag);
    check($sformatf("%s_tx_valid", tag), tx_valid, 0);
    check($sformatf("%s_tx_data", tag), tx_data, 0);
    check($sformatf("%s_rd_en", tag), mem_rd_en, 0);
    check($sformatf("%s_addr", tag), mem_addr, 0);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_done", tag), done, 0);
  endtask
  initial begin
    int t, n;
    #1;
    check_idle_outputs("rst");
    repeat (3) @(posedge sclk);
    #1;
    rst_n = 1;
    for (int i = 0; i < PL; i++) mem[i] = 8'(8'h11 * (i + 1));
    run_frame(0, 0, "wr_fix");
    run_frame(1, 0, "rd");
    pct = 30;
    run_frame(0, 0, "wr_stall");
    pct = 100;
    run_frame(0, 1, "dbl_start");
    for (int i = 0; i < PL; i++) mem[i] = 8'($urandom);
    pulse_start(0);
    t = 0;
    while (obs_q.size() < PC + 10 && t < 2000) begin
      @(posedge sclk); #1;
      t++;
    end
    check("midrst_timeout", t < 2000, 1);
    #2;
    rst_n = 0;
    #1;
    check_idle_outputs("midrst");
    @(posedge sclk); #1;
    rst_n = 1;
    n = obs_q.size();
    repeat (20) @(posedge sclk);
    #1;
    check("midrst_silent", obs_q.size(), n);
    check("midrst_valid", tx_valid, 0);
    run_frame(0, 0, "post_rst");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < PL; i++) mem[i] = 8'($urandom);
      pct = $urandom_range(100, 20);
      run_frame(1'($urandom), 0, $sformatf("rnd%0d", k));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/frame_tx.md
FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 SHALL provide parameter PAYLOAD_LEN, default 40000, payload bytes per write frame (1..65536).
REQ-002 SHALL provide parameter PRE_CNT, default 7, number of 0x55 preamble bytes.
REQ-003 SHALL provide port sclk  input  1  system clock; all logic on posedge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port start  input  1  single-cycle frame request; sampled only in IDLE.
REQ-006 SHALL provide port cmd_sel  input  1  sampled with start; 0 = write frame (cmd 0xAA + payload), 1 = read-request frame (cmd 0x55, header only).
REQ-007 SHALL provide port mem_rd_en  output  1  frame-memory read strobe.
REQ-008 SHALL provide port mem_addr  output  16  frame-memory read address.
REQ-009 SHALL provide port mem_rd_data  input  8  read data, valid exactly 1 cycle after mem_rd_en.
REQ-010 SHALL provide port tx_data  output  8  byte to UART transmitter.
REQ-011 SHALL provide port tx_valid  output  1  tx_data valid.
REQ-012 SHALL provide port tx_ready  input  1  UART transmitter can accept a byte.
REQ-013 SHALL provide port busy  output  1  high from accepted start until done.
REQ-014 SHALL provide port done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-015 SHALL transfer a byte only on a cycle where tx_valid && tx_ready; tx_data SHALL stay stable while tx_valid is high and not accepted.
REQ-016 SHALL implement states IDLE, PRE, SFD, ID, CMD, LEN0, LEN1, P_RD, P_TX, CSUM, FIN.
REQ-017 IDLE -> PRE on start; latch cmd_sel; busy rises the next cycle.
REQ-018 PRE SHALL send 0x55 PRE_CNT times (counter 0..PRE_CNT-1), then SFD sends 0xD5, ID sends 0xFA, CMD sends 0xAA (write) or 0x55 (read), LEN0 and LEN1 send 0x00 each; each state advances only on acceptance.
REQ-019 After LEN1: write frame -> P_RD; read frame -> FIN (CSUM state skipped when macro absent).
REQ-020 P_RD SHALL assert mem_rd_en for one cycle at mem_addr, tx_valid low; P_TX SHALL present mem_rd_data (registered) with tx_valid high until accepted.
REQ-021 mem_addr SHALL start at 0 per frame, increment after each accepted payload byte, and reach PAYLOAD_LEN-1 on the last byte; then P_TX -> CSUM/FIN, mem_addr -> 0.
REQ-022 FIN SHALL pulse done for one cycle, drop busy, return to IDLE.
REQ-023 start asserted while busy SHALL be ignored (not queued).
REQ-024 tx_ready held low indefinitely SHALL stall the FSM with no byte loss or duplication.
REQ-025 Byte counter SHALL be 16 bits; comparisons against PAYLOAD_LEN-1 SHALL be exact (no wrap past 0xFFFF).

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, tx_data=0, tx_valid=0, mem_rd_en=0, mem_addr=0, busy=0, done=0, all counters and checksum 0.
REQ-027 Reset mid-frame SHALL abandon the frame; after release no byte SHALL be sent until a new start.

Configuration
REQ-028 With FRAME_TX_CHKSUM_EN defined, after the last payload byte (write) or LEN1 (read) CSUM SHALL send the 8-bit modulo-256 sum of all bytes from CMD through last payload byte, then FIN.
REQ-029 Without FRAME_TX_CHKSUM_EN, CSUM state and accumulator SHALL not exist; frame ends at last payload byte / LEN1.

Structure
REQ-030 Shared package frame_pkg SHALL hold state encoding, byte constants (0x55, 0xD5, 0xFA, 0xAA, 0x00) and default PAYLOAD_LEN, shared with the frame receiver.
REQ-031 Single module, no sub-module; UART transmitter and frame memory are external.

Verification
REQ-032 PAYLOAD_LEN=4, memory {11,22,33,44}, tx_ready=1, cmd_sel=0, start -> bytes 55x7,D5,FA,AA,00,00,11,22,33,44 then done pulse.
REQ-033 cmd_sel=1, start -> 55x7,D5,FA,55,00,00, no mem_rd_en, done pulse.
REQ-034 tx_ready toggled pseudo-randomly 30% high -> identical byte sequence as REQ-032, tx_data stable while stalled.
REQ-035 start pulsed again during payload -> ignored; exactly one frame, one done.
REQ-036 rst_n low after 5th payload byte of PAYLOAD_LEN=8 -> outputs zero immediately; next start sends full frame from address 0.
REQ-037 FRAME_TX_CHKSUM_EN, REQ-032 stimulus -> extra byte 0x54 (AA+11+22+33+44 mod 256) before done.
